bp_be_dep_tracker: RTL and testbench

- Parametrised successor to the BE issue-stage dependency detector for a single register class; instantiated once per register file (integer with zero_reg_p=1, FP with zero_reg_p=0).
- Tracks in-flight producers in a depth_p-stage shift chain that carries per-instruction forwarding latency, so stage-specific hazard equations are not hand-written.
- Late (unbounded-latency) producers move into a per-register counting scoreboard that allows multiple outstanding writes per register.
- Produces per-source RAW and destination WAW stall signals for dispatch.

---
 rtl/bp_be_dep_tracker_if.sv | 38 +++
 rtl/bp_be_dep_tracker.sv | 130 +++++++++++++
 tb/tb_bp_be_dep_tracker.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bp_be_dep_tracker_if.sv
// rtl/bp_be_dep_tracker_if.sv - issue/dispatch/writeback bundle for the dependency tracker
interface bp_be_dep_tracker_if #(
  parameter int num_rs_p         = 3,
  parameter int reg_addr_width_p = 5,
  parameter int lat_width_p      = 3,
  parameter int depth_p          = 5
);
  logic                                 isd_v_i;
  logic [num_rs_p-1:0]                  isd_rs_v_i;
  logic [num_rs_p*reg_addr_width_p-1:0] isd_rs_addr_i;
  logic                                 isd_rd_v_i;
  logic [reg_addr_width_p-1:0]          isd_rd_addr_i;
  logic                                 dispatch_v_i;
  logic                                 dispatch_rd_v_i;
  logic [reg_addr_width_p-1:0]          dispatch_rd_addr_i;
  logic [lat_width_p-1:0]               dispatch_lat_i;
  logic                                 dispatch_late_i;
  logic [depth_p-1:0]                   flush_i;
  logic                                 clear_v_i;
  logic [reg_addr_width_p-1:0]          clear_rd_addr_i;
  logic [num_rs_p-1:0]                  rs_haz_o;
  logic                                 rd_haz_o;
  logic                                 haz_o;

  modport master (
    output isd_v_i, isd_rs_v_i, isd_rs_addr_i, isd_rd_v_i, isd_rd_addr_i,
    output dispatch_v_i, dispatch_rd_v_i, dispatch_rd_addr_i, dispatch_lat_i, dispatch_late_i,
    output flush_i, clear_v_i, clear_rd_addr_i,
    input  rs_haz_o, rd_haz_o, haz_o
  );

  modport slave (
    input  isd_v_i, isd_rs_v_i, isd_rs_addr_i, isd_rd_v_i, isd_rd_addr_i,
    input  dispatch_v_i, dispatch_rd_v_i, dispatch_rd_addr_i, dispatch_lat_i, dispatch_late_i,
    input  flush_i, clear_v_i, clear_rd_addr_i,
    output rs_haz_o, rd_haz_o, haz_o
  );
endinterface

// File: rtl/bp_be_dep_tracker.sv
// rtl/bp_be_dep_tracker.sv - issue-stage RAW/WAW detector: latency-carrying shift chain
// plus a counting scoreboard for late-writeback producers
module bp_be_dep_tracker #(
  parameter int depth_p          = 5,
  parameter int num_rs_p         = 3,
  parameter int reg_addr_width_p = 5,
  parameter int lat_width_p      = 3,
  parameter int sb_cnt_width_p   = 2,
  parameter int zero_reg_p       = 1
) (
  input logic               clk_i,
  input logic               reset_i,
  bp_be_dep_tracker_if.slave io
);

  localparam int num_regs_lp = 1 << reg_addr_width_p;

  typedef logic [reg_addr_width_p-1:0] addr_t;
  typedef logic [lat_width_p-1:0]      lat_t;
  typedef logic [sb_cnt_width_p-1:0]   cnt_t;

  localparam lat_t lat_one_lp = lat_t'(1);
  localparam cnt_t cnt_one_lp = cnt_t'(1);

  logic [depth_p-1:0] v_r;
  logic [depth_p-1:0] late_r;
  addr_t              rd_r  [depth_p];
  lat_t               rem_r [depth_p];
  cnt_t               cnt_r [num_regs_lp];

  logic                   disp_load;
  logic                   exit_inc;
  logic [num_regs_lp-1:0] inc_vec;
  logic [num_regs_lp-1:0] dec_vec;
  logic [num_rs_p-1:0]    rs_haz;
  logic                   rd_late_hit;
  logic                   rd_haz;

  function automatic logic is_zero(input addr_t a);
    return (zero_reg_p != 0) && (a == '0);
  endfunction

  function automatic lat_t dec_rem(input lat_t r);
    return (r == '0) ? '0 : r - lat_one_lp;
  endfunction

  assign disp_load = io.dispatch_v_i & io.dispatch_rd_v_i & ~is_zero(io.dispatch_rd_addr_i);
  assign exit_inc  = v_r[depth_p-1] & late_r[depth_p-1] & ~io.flush_i[depth_p-1];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r <= '0;
    end else begin
      v_r[0] <= disp_load;
      for (int i = 1; i < depth_p; i++) begin
        v_r[i] <= v_r[i-1] & ~io.flush_i[i-1];
      end
    end
  end

  // Late producers carry all-ones so they never look forwardable while in the chain
  always_ff @(posedge clk_i) begin
    rd_r[0]   <= io.dispatch_rd_addr_i;
    late_r[0] <= io.dispatch_late_i;
    rem_r[0]  <= io.dispatch_late_i ? '1 : io.dispatch_lat_i;
    for (int i = 1; i < depth_p; i++) begin
      rd_r[i]   <= rd_r[i-1];
      late_r[i] <= late_r[i-1];
      rem_r[i]  <= dec_rem(rem_r[i-1]);
    end
  end

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < num_regs_lp; r++) begin
      inc_vec[r] = exit_inc & (rd_r[depth_p-1] == addr_t'(r));
      dec_vec[r] = io.clear_v_i & (io.clear_rd_addr_i == addr_t'(r)) & (cnt_r[r] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < num_regs_lp; r++) cnt_r[r] <= '0;
    end else begin
      for (int r = 0; r < num_regs_lp; r++) begin
        if (inc_vec[r] & ~dec_vec[r])
          cnt_r[r] <= cnt_r[r] + cnt_one_lp;
        else if (dec_vec[r] & ~inc_vec[r])
          cnt_r[r] <= cnt_r[r] - cnt_one_lp;
      end
    end
  end

  for (genvar k = 0; k < num_rs_p; k++) begin : g_rs
    addr_t rs_addr;
    logic  chain_hit;
    assign rs_addr = io.isd_rs_addr_i[k*reg_addr_width_p +: reg_addr_width_p];
    always_comb begin
      chain_hit = 1'b0;
      for (int i = 0; i < depth_p; i++) begin
        chain_hit = chain_hit | (v_r[i] & (rd_r[i] == rs_addr) & (rem_r[i] != '0));
      end
    end
    assign rs_haz[k] = io.isd_v_i & io.isd_rs_v_i[k] & ~is_zero(rs_addr)
                     & (chain_hit | (cnt_r[rs_addr] != '0));
  end

  always_comb begin
    rd_late_hit = 1'b0;
    for (int i = 0; i < depth_p; i++) begin
      rd_late_hit = rd_late_hit | (v_r[i] & late_r[i] & (rd_r[i] == io.isd_rd_addr_i));
    end
  end

  assign rd_haz = io.isd_v_i & io.isd_rd_v_i & ~is_zero(io.isd_rd_addr_i)
                & ((cnt_r[io.isd_rd_addr_i] == '1) | rd_late_hit);

  assign io.rs_haz_o = rs_haz;
  assign io.rd_haz_o = rd_haz;
  assign io.haz_o    = (|rs_haz) | rd_haz;

  // A remainder of one is consumed by the exit shift itself; anything larger means lat > depth
  assert property (@(posedge clk_i) disable iff (reset_i)
    !(v_r[depth_p-1] & ~late_r[depth_p-1] & (rem_r[depth_p-1] > lat_one_lp)));

  assert property (@(posedge clk_i) disable iff (reset_i)
    !(io.clear_v_i && (cnt_r[io.clear_rd_addr_i] == '0)));

endmodule

// File: tb/tb_bp_be_dep_tracker.sv
// tb/tb_bp_be_dep_tracker.sv - bench for bp_be_dep_tracker, zero-reg and non-zero-reg instances
module tb_bp_be_dep_tracker;
  localparam int DEPTH = 5;
  localparam int NRS   = 3;
  localparam int AW    = 5;
  localparam int LW    = 3;
  localparam int CW    = 2;
  localparam int CMAX  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              isd_v;
  logic [NRS-1:0]    isd_rs_v;
  logic [NRS*AW-1:0] isd_rs_addr;
  logic              isd_rd_v;
  logic [AW-1:0]     isd_rd_addr;
  logic              disp_v, disp_rd_v, disp_late;
  logic [AW-1:0]     disp_rd;
  logic [LW-1:0]     disp_lat;
  logic [DEPTH-1:0]  flush;
  logic              clear_v;
  logic [AW-1:0]     clear_rd;

  int errors = 0;
  int checks = 0;

  bp_be_dep_tracker_if #(.num_rs_p(NRS), .reg_addr_width_p(AW), .lat_width_p(LW), .depth_p(DEPTH)) ifz ();
  bp_be_dep_tracker_if #(.num_rs_p(NRS), .reg_addr_width_p(AW), .lat_width_p(LW), .depth_p(DEPTH)) ifn ();

  assign ifz.isd_v_i = isd_v;                 assign ifn.isd_v_i = isd_v;
  assign ifz.isd_rs_v_i = isd_rs_v;           assign ifn.isd_rs_v_i = isd_rs_v;
  assign ifz.isd_rs_addr_i = isd_rs_addr;     assign ifn.isd_rs_addr_i = isd_rs_addr;
  assign ifz.isd_rd_v_i = isd_rd_v;           assign ifn.isd_rd_v_i = isd_rd_v;
  assign ifz.isd_rd_addr_i = isd_rd_addr;     assign ifn.isd_rd_addr_i = isd_rd_addr;
  assign ifz.dispatch_v_i = disp_v;           assign ifn.dispatch_v_i = disp_v;
  assign ifz.dispatch_rd_v_i = disp_rd_v;     assign ifn.dispatch_rd_v_i = disp_rd_v;
  assign ifz.dispatch_rd_addr_i = disp_rd;    assign ifn.dispatch_rd_addr_i = disp_rd;
  assign ifz.dispatch_lat_i = disp_lat;       assign ifn.dispatch_lat_i = disp_lat;
  assign ifz.dispatch_late_i = disp_late;     assign ifn.dispatch_late_i = disp_late;
  assign ifz.flush_i = flush;                 assign ifn.flush_i = flush;
  assign ifz.clear_v_i = clear_v;             assign ifn.clear_v_i = clear_v;
  assign ifz.clear_rd_addr_i = clear_rd;      assign ifn.clear_rd_addr_i = clear_rd;

  bp_be_dep_tracker #(.depth_p(DEPTH), .num_rs_p(NRS), .reg_addr_width_p(AW), .lat_width_p(LW),
                      .sb_cnt_width_p(CW), .zero_reg_p(1))
    dut_z (.clk_i(clk), .reset_i(reset), .io(ifz));

  bp_be_dep_tracker #(.depth_p(DEPTH), .num_rs_p(NRS), .reg_addr_width_p(AW), .lat_width_p(LW),
                      .sb_cnt_width_p(CW), .zero_reg_p(0))
    dut_n (.clk_i(clk), .reset_i(reset), .io(ifn));

  // Reference: in-flight producers by age since dispatch; index 0 models zero_reg_p=1, 1 models 0
  typedef struct {
    int rd;
    int lat;
    bit late;
    int age;
    bit alive;
  } ent_t;

  ent_t q0[$];
  ent_t q1[$];
  int   cnt [2][32];

  function automatic bit busy(int n, int a, bit for_rd);
    ent_t e;
    int   sz;
    if (n == 0 && a == 0) return 1'b0;
    if (for_rd && cnt[n][a] >= CMAX) return 1'b1;
    if (!for_rd && cnt[n][a] != 0) return 1'b1;
    sz = (n == 0) ? q0.size() : q1.size();
    for (int i = 0; i < sz; i++) begin
      e = (n == 0) ? q0[i] : q1[i];
      if (e.alive && e.rd == a && (e.late || (!for_rd && e.lat > e.age))) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int expect_out(int n);
    logic [NRS-1:0] rs;
    logic           rdh;
    for (int k = 0; k < NRS; k++)
      rs[k] = isd_v && isd_rs_v[k] && busy(n, int'(isd_rs_addr[k*AW +: AW]), 1'b0);
    rdh = isd_v && isd_rd_v && busy(n, int'(isd_rd_addr), 1'b1);
    return int'({(|rs) | rdh, rdh, rs});
  endfunction

  function automatic int load_of(int n, int a);
    int s;
    s = cnt[n][a];
    if (n == 0) begin
      foreach (q0[i]) if (q0[i].late && q0[i].rd == a) s++;
    end else begin
      foreach (q1[i]) if (q1[i].late && q1[i].rd == a) s++;
    end
    return s;
  endfunction

  task automatic advance(int n, inout ent_t qq[$]);
    ent_t nq[$];
    ent_t e;
    bit   dec;
    dec = clear_v && cnt[n][int'(clear_rd)] > 0;
    foreach (qq[i]) begin
      e = qq[i];
      if (flush[e.age]) e.alive = 1'b0;
      e.age++;
      if (e.age == DEPTH) begin
        if (e.alive && e.late) cnt[n][e.rd]++;
      end else begin
        nq.push_back(e);
      end
    end
    if (dec) cnt[n][int'(clear_rd)]--;
    if (disp_v && disp_rd_v && !(n == 0 && disp_rd == '0)) begin
      e.rd = int'(disp_rd); e.lat = int'(disp_lat); e.late = disp_late; e.age = 0; e.alive = 1'b1;
      nq.push_back(e);
    end
    qq = nq;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q0.delete();
      q1.delete();
      for (int n = 0; n < 2; n++) for (int r = 0; r < 32; r++) cnt[n][r] = 0;
    end else begin
      advance(0, q0);
      advance(1, q1);
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (!reset) begin
      chk("model_z", int'({ifz.haz_o, ifz.rd_haz_o, ifz.rs_haz_o}), expect_out(0));
      chk("model_n", int'({ifn.haz_o, ifn.rd_haz_o, ifn.rs_haz_o}), expect_out(1));
    end
  end

  task automatic nxt();
    @(negedge clk);
    disp_v = 1'b0; disp_rd_v = 1'b0; disp_late = 1'b0; disp_lat = '0; disp_rd = '0;
    flush = '0; clear_v = 1'b0; clear_rd = '0;
  endtask

  task automatic issue(int rs0, bit rs0_v, int rd, bit rd_v);
    isd_v = 1'b1;
    isd_rs_v = {2'b00, rs0_v};
    isd_rs_addr = '0;
    isd_rs_addr[AW-1:0] = AW'(rs0);
    isd_rd_v = rd_v;
    isd_rd_addr = AW'(rd);
  endtask

  task automatic disp(int rd, int lat, bit late);
    disp_v = 1'b1; disp_rd_v = 1'b1; disp_rd = AW'(rd); disp_lat = LW'(lat); disp_late = late;
  endtask

  initial begin
    int a;
    isd_v = 0; isd_rs_v = '0; isd_rs_addr = '0; isd_rd_v = 0; isd_rd_addr = '0;
    disp_v = 0; disp_rd_v = 0; disp_late = 0; disp_rd = '0; disp_lat = '0;
    flush = '0; clear_v = 0; clear_rd = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Empty state, and dispatch x5 lat=2
    nxt(); reset = 1'b0; issue(5, 1, 0, 0); isd_rs_v = 3'b111; disp(5, 2, 0);
    #3 chk("empty_rs", int'(ifz.rs_haz_o), 0); chk("empty_haz", int'(ifn.haz_o), 0);
    isd_rs_v = 3'b001;
    nxt(); #3 chk("lat2_c1", int'(ifz.rs_haz_o[0]), 1);
    nxt(); #3 chk("lat2_c2", int'(ifz.rs_haz_o[0]), 1);
    nxt(); disp(7, 0, 0); #3 chk("lat2_c3", int'(ifz.rs_haz_o[0]), 0);
    nxt(); issue(7, 1, 0, 0); disp(3, 0, 1); #3 chk("lat0_x7", int'(ifz.rs_haz_o[0]), 0);

    // Late x3: chain residency, scoreboard, clear
    for (int c = 0; c < 6; c++) begin
      nxt(); issue(3, 1, 0, 0);
      if (c == 5) begin clear_v = 1'b1; clear_rd = AW'(3); end
      #3 chk($sformatf("late_x3_c%0d", c), int'(ifz.rs_haz_o[0]), 1);
    end
    nxt(); #3 chk("late_x3_cleared", int'(ifz.haz_o), 0);

    // Four late x4 writes; the fourth exits together with a clear
    for (int c = 0; c <= 12; c++) begin
      nxt(); issue(4, 1, 4, 1);
      if (c <= 3) disp(4, 0, 1);
      if (c >= 8 && c <= 11) begin clear_v = 1'b1; clear_rd = AW'(4); end
      #3;
      chk($sformatf("x4_rd_c%0d", c), int'(ifz.rd_haz_o), (c >= 1 && c <= 9) ? 1 : 0);
      chk($sformatf("x4_rs_c%0d", c), int'(ifn.rs_haz_o[0]), (c >= 1 && c <= 11) ? 1 : 0);
    end

    // Late x9 flushed in stage 2
    for (int c = 0; c <= 8; c++) begin
      nxt(); issue(9, 1, 0, 0);
      if (c == 0) disp(9, 0, 1);
      if (c == 3) flush = 5'b00100;
      #3 chk($sformatf("flush_x9_c%0d", c), int'(ifz.rs_haz_o[0]), (c >= 1 && c <= 3) ? 1 : 0);
    end

    // Register 0 on both instances
    for (int c = 0; c <= 4; c++) begin
      nxt(); issue(0, 1, 0, 1);
      if (c == 0) disp(0, 3, 0);
      #3;
      chk($sformatf("x0_zero_c%0d", c), int'(ifz.haz_o), 0);
      chk($sformatf("x0_plain_c%0d", c), int'(ifn.rs_haz_o[0]), (c >= 1 && c <= 3) ? 1 : 0);
    end

    // Randomized traffic with a mid-run reset
    for (int it = 0; it < 3000; it++) begin
      nxt();
      isd_v = ($urandom_range(0, 3) != 0);
      isd_rs_v = NRS'($urandom);
      for (int k = 0; k < NRS; k++) isd_rs_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
      isd_rd_v = $urandom_range(0, 1) == 1;
      isd_rd_addr = AW'($urandom_range(0, 7));
      for (int i = 0; i < DEPTH; i++) flush[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 3) == 0) begin
          a = $urandom_range(1, 7);
          if (load_of(0, a) < CMAX && load_of(1, a) < CMAX) disp(a, 0, 1);
        end else begin
          disp($urandom_range(0, 7), $urandom_range(0, DEPTH), 0);
          disp_rd_v = ($urandom_range(0, 3) != 0);
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        a = $urandom_range(1, 7);
        if (cnt[0][a] > 0 && cnt[1][a] > 0) begin clear_v = 1'b1; clear_rd = AW'(a); end
      end
      if (it == 1500 || it == 1501) begin
        reset = 1'b1; clear_v = 1'b1; clear_rd = AW'($urandom_range(1, 7));
      end
      if (it == 1502) begin
        reset = 1'b0;
        disp_v = 1'b0; clear_v = 1'b0;
        isd_v = 1'b1; isd_rs_v = '1; isd_rd_v = 1'b1;
        #3 chk("post_reset_z", int'(ifz.haz_o), 0); chk("post_reset_n", int'(ifn.haz_o), 0);
      end
    end

    nxt();
    isd_v = 1'b0;
    repeat (DEPTH + 2) nxt();
    #3 chk("idle_end", int'(ifz.haz_o | ifn.haz_o), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
